sprite_engine: RTL and testbench

- Per-scanline sprite compositor. On a start pulse, issued after the tile layer has filled the draw-side line buffer, it scans a 32-entry sprite attribute table.
- For every 16x16 sprite that intersects the target line, it fetches that row's pixels from sprite pixel memory and overwrites the matching draw line-buffer entries.
- Transparent pixels are skipped. Lower-index sprites have higher priority.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/sprite_attr_ram.sv | 24 ++
 rtl/sprite_engine.sv | 152 +++++++++++++++
 tb/tb_sprite_engine.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: sprite attribute layout, pixel constants and
// the sprite compositor state encoding.
package vga_pkg;

  localparam int SPR_DIM           = 16;
  localparam int PIX_TRANSP_BIT    = 15;
  localparam int H_VISIBLE_DEFAULT = 640;

  typedef struct packed {
    logic       enable;
    logic       hflip;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] rsvd;
    logic [7:0] frame;
  } sprite_attr_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DRAW  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Column within the 16-pixel sprite row, mirrored when hflip is set (15-c == ~c).
  function automatic logic [3:0] spr_col(input logic hflip, input logic [3:0] c);
    return hflip ? ~c : c;
  endfunction

endpackage

// File: rtl/sprite_attr_ram.sv
// Sprite attribute table: one write port, one registered read port.
// A read of an entry written in the same cycle returns the previous contents.
module sprite_attr_ram #(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array and read register are deliberately not reset; the table
  // survives reset and read data is only consumed after a FETCH cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_engine.sv
// Per-scanline sprite compositor: scans the attribute table from the highest
// index down and overwrites draw line-buffer pixels for every intersecting sprite.
module sprite_engine
  import vga_pkg::*;
#(
  parameter  int NUM_SPRITES = 32,
  parameter  int H_VISIBLE   = H_VISIBLE_DEFAULT,
  localparam int IW          = $clog2(NUM_SPRITES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [9:0]    line,
  input  logic          attr_we,
  input  logic [IW-1:0] attr_addr,
  input  logic [31:0]   attr_wdata,
  output logic [15:0]   pix_addr,
  input  logic [15:0]   pix_rdata,
  output logic [9:0]    lb_addr,
  output logic [15:0]   lb_data,
  output logic          lb_wren,
  output logic          busy,
  output logic          done,
  output logic [IW:0]   hit_count
);

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [9:0]    line_q;
  logic [IW:0]   hits;

  logic [31:0]   rd_word;
  sprite_attr_t  attr;
  logic [9:0]    dy;
  logic          hit;
  logic          unused_rsvd;

  logic [9:0]    cur_x;
  logic          cur_hflip;
  logic [7:0]    cur_frame;
  logic [3:0]    cur_row;
  logic [3:0]    col;
  logic [10:0]   draw_x;

  logic          wr_valid;
  logic [9:0]    wr_addr;
  logic          wr_in_range;

  sprite_attr_ram #(.DEPTH(NUM_SPRITES)) u_attr_ram (
    .clk   (clk),
    .we    (attr_we),
    .waddr (attr_addr),
    .wdata (attr_wdata),
    .raddr (idx),
    .rdata (rd_word)
  );

  assign attr        = sprite_attr_t'(rd_word);
  assign unused_rsvd = ^attr.rsvd;
  assign dy          = line_q - attr.y;
  assign hit         = attr.enable && (line_q >= attr.y) && (dy < 10'(SPR_DIM));
  assign draw_x      = {1'b0, cur_x} + {7'b0, col};

  // Write stage is one cycle behind the address stage, lined up with pix_rdata.
  assign lb_addr = wr_addr;
  assign lb_data = wr_valid ? pix_rdata : 16'h0000;
  assign lb_wren = wr_valid && !pix_rdata[PIX_TRANSP_BIT] && wr_in_range;

  // NOTE: all state below is registered with non-blocking assignments so every
  // branch sees the pre-edge values of state, idx and col.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      line_q      <= '0;
      hits        <= '0;
      hit_count   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pix_addr    <= '0;
      cur_x       <= '0;
      cur_hflip   <= 1'b0;
      cur_frame   <= '0;
      cur_row     <= '0;
      col         <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_in_range <= 1'b0;
    end else begin
      wr_valid    <= (state == ST_DRAW);
      wr_addr     <= draw_x[9:0];
      wr_in_range <= (draw_x < 11'(H_VISIBLE));

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            line_q <= line;
            done   <= 1'b0;
            busy   <= 1'b1;
            hits   <= '0;
            idx    <= IW'(NUM_SPRITES - 1);
            state  <= ST_FETCH;
          end
        end

        ST_FETCH: state <= ST_CHECK;

        ST_CHECK: begin
          if (hit) begin
            hits      <= hits + 1'b1;
            cur_x     <= attr.x;
            cur_hflip <= attr.hflip;
            cur_frame <= attr.frame;
            cur_row   <= dy[3:0];
            col       <= '0;
            pix_addr  <= {attr.frame, dy[3:0], spr_col(attr.hflip, 4'd0)};
            state     <= ST_DRAW;
          end else if (idx == '0) begin
            state <= ST_DRAIN;
          end else begin
            idx   <= idx - 1'b1;
            state <= ST_FETCH;
          end
        end

        ST_DRAW: begin
          if (col == 4'hF) begin
            if (idx == '0) begin
              state <= ST_DRAIN;
            end else begin
              idx   <= idx - 1'b1;
              state <= ST_FETCH;
            end
          end else begin
            col      <= col + 1'b1;
            pix_addr <= {cur_frame, cur_row, spr_col(cur_hflip, col + 1'b1)};
          end
        end

        ST_DRAIN: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          hit_count <= hits;
          state     <= ST_DONE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Directed self-checking bench for sprite_engine: timing, pixel addressing,
// clipping, transparency, priority and reset behaviour.
module tb_sprite_engine;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  line;
  logic        attr_we;
  logic [4:0]  attr_addr;
  logic [31:0] attr_wdata;
  logic [15:0] pix_addr;
  logic [15:0] pix_rdata;
  logic [9:0]  lb_addr;
  logic [15:0] lb_data;
  logic        lb_wren;
  logic        busy;
  logic        done;
  logic [5:0]  hit_count;

  int vectors     = 0;
  int miscompares = 0;
  int pix_mode    = 0;
  int cyc;

  logic [9:0]  wa[$];
  logic [15:0] wd[$];
  logic [15:0] wp[$];
  logic [15:0] prev_pa;

  always #10 clk = ~clk;

  sprite_engine #(.NUM_SPRITES(32), .H_VISIBLE(640)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .line       (line),
    .attr_we    (attr_we),
    .attr_addr  (attr_addr),
    .attr_wdata (attr_wdata),
    .pix_addr   (pix_addr),
    .pix_rdata  (pix_rdata),
    .lb_addr    (lb_addr),
    .lb_data    (lb_data),
    .lb_wren    (lb_wren),
    .busy       (busy),
    .done       (done),
    .hit_count  (hit_count)
  );

  // Pixel memory: mode 0 all opaque 0x1234, mode 1 even columns transparent,
  // mode 2 opaque with the frame number as colour.
  function automatic logic [15:0] pix_model(input logic [15:0] a);
    case (pix_mode)
      1:       return a[0] ? 16'h1234 : 16'h8000;
      2:       return {8'h00, a[15:8]};
      default: return 16'h1234;
    endcase
  endfunction

  always @(posedge clk) pix_rdata <= pix_model(pix_addr);

  // Line-buffer write log, each write tagged with the address issued a cycle earlier.
  always @(negedge clk) begin
    if (lb_wren) begin
      wa.push_back(lb_addr);
      wd.push_back(lb_data);
      wp.push_back(prev_pa);
    end
    prev_pa = pix_addr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic en, input logic hf, input logic [9:0] x,
                                     input logic [9:0] y, input logic [7:0] fr);
    sprite_attr_t s;
    s.enable = en;
    s.hflip  = hf;
    s.x      = x;
    s.y      = y;
    s.rsvd   = 2'b11;
    s.frame  = fr;
    return s;
  endfunction

  task automatic write_attr(input int i, input logic [31:0] w);
    @(negedge clk);
    attr_we    = 1'b1;
    attr_addr  = 5'(i);
    attr_wdata = w;
    @(negedge clk);
    attr_we    = 1'b0;
  endtask

  function automatic logic [15:0] last_write(input logic [9:0] a);
    for (int i = wa.size() - 1; i >= 0; i--)
      if (wa[i] == a) return wd[i];
    return 16'hFFFF;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_addr"},  pix_addr,  32'h0);
    check({tag, "_lb_addr"},   lb_addr,   32'h0);
    check({tag, "_lb_data"},   lb_data,   32'h0);
    check({tag, "_lb_wren"},   lb_wren,   32'h0);
    check({tag, "_busy"},      busy,      32'h0);
    check({tag, "_done"},      done,      32'h0);
    check({tag, "_hit_count"}, hit_count, 32'h0);
  endtask

  // Raise start after posedge P0 (accepted at P1); return the number of edges
  // after P0 at which done is first seen high. poke != 0 re-pulses start mid-run.
  task automatic run_line(input string tag, input logic [9:0] l, input int poke, output int n);
    wa.delete(); wd.delete(); wp.delete();
    @(posedge clk); #1 start = 1'b1; line = l;
    @(posedge clk); #1 start = 1'b0;
    n = 1;
    check({tag, "_busy_after_start"}, {busy, done}, 32'h2);
    while (!done && n < 1000) begin
      start = (poke != 0 && n == poke);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, "_idle_after_done"}, {busy, done}, 32'h1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; line = '0;
    attr_we = 1'b0; attr_addr = '0; attr_wdata = '0;

    // Reset state
    #35;
    check_reset_outputs("reset");
    @(negedge clk); reset = 1'b0;

    // All sprites disabled
    for (int i = 0; i < 32; i++) write_attr(i, mk(1'b0, 1'b0, 10'd0, 10'd100, 8'd0));
    run_line("none", 10'd100, 0, cyc);
    check("none_cycles", cyc, 66);
    check("none_writes", wa.size(), 0);
    check("none_hits", hit_count, 0);

    // Single opaque sprite
    write_attr(5, mk(1'b1, 1'b0, 10'd10, 10'd96, 8'd3));
    run_line("one", 10'd100, 0, cyc);
    check("one_cycles", cyc, 82);
    check("one_hits", hit_count, 1);
    check("one_writes", wa.size(), 16);
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      check("one_lb_addr", wa[i], 10 + i);
      check("one_pix_addr", wp[i], 16'h0340 + 16'(i));
      check("one_lb_data", wd[i], 16'h1234);
    end

    // Same sprite mirrored
    write_attr(5, mk(1'b1, 1'b1, 10'd10, 10'd96, 8'd3));
    run_line("hflip", 10'd100, 0, cyc);
    check("hflip_cycles", cyc, 82);
    check("hflip_writes", wa.size(), 16);
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      check("hflip_lb_addr", wa[i], 10 + i);
      check("hflip_pix_addr", wp[i], 16'h034F - 16'(i));
    end

    // Right-edge clipping with transparent even columns
    write_attr(5, mk(1'b0, 1'b0, 10'd10, 10'd96, 8'd3));
    write_attr(2, mk(1'b1, 1'b0, 10'd630, 10'd100, 8'd7));
    pix_mode = 1;
    run_line("clip", 10'd100, 0, cyc);
    check("clip_cycles", cyc, 82);
    check("clip_writes", wa.size(), 5);
    for (int i = 0; i < 5 && i < wa.size(); i++) begin
      check("clip_lb_addr", wa[i], 631 + 2 * i);
      check("clip_pix_addr", wp[i], 16'h0701 + 16'(2 * i));
    end

    // Overlap priority plus vertical boundaries (dy = 15 hits, dy = 16 and y > line miss)
    write_attr(2, mk(1'b0, 1'b0, 10'd630, 10'd100, 8'd7));
    write_attr(0, mk(1'b1, 1'b0, 10'd50, 10'd100, 8'd1));
    write_attr(1, mk(1'b1, 1'b0, 10'd58, 10'd98, 8'd2));
    write_attr(3, mk(1'b1, 1'b0, 10'd300, 10'd101, 8'd9));
    write_attr(4, mk(1'b1, 1'b0, 10'd400, 10'd84, 8'd9));
    write_attr(6, mk(1'b1, 1'b0, 10'd200, 10'd85, 8'd4));
    pix_mode = 2;
    run_line("prio", 10'd100, 0, cyc);
    check("prio_cycles", cyc, 114);
    check("prio_hits", hit_count, 3);
    check("prio_writes", wa.size(), 48);
    check("prio_final_50", last_write(10'd50), 16'h0001);
    check("prio_final_58", last_write(10'd58), 16'h0001);
    check("prio_final_65", last_write(10'd65), 16'h0001);
    check("prio_final_66", last_write(10'd66), 16'h0002);
    check("prio_final_73", last_write(10'd73), 16'h0002);
    check("prio_final_74", last_write(10'd74), 16'hFFFF);
    check("prio_final_200", last_write(10'd200), 16'h0004);
    check("prio_final_215", last_write(10'd215), 16'h0004);
    check("prio_y_above", last_write(10'd300), 16'hFFFF);
    check("prio_dy16", last_write(10'd400), 16'hFFFF);

    // Reset while sprite 6 is drawing
    @(posedge clk); #1 start = 1'b1; line = 10'd100;
    @(posedge clk); #1 start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("middraw_wren", lb_wren, 1);
    check("middraw_busy", busy, 1);
    #4 reset = 1'b1;
    #1;
    check_reset_outputs("middraw_reset");
    @(negedge clk); reset = 1'b0;

    run_line("after_reset", 10'd100, 0, cyc);
    check("after_reset_cycles", cyc, 114);
    check("after_reset_hits", hit_count, 3);
    check("after_reset_writes", wa.size(), 48);

    // Start pulse while busy is ignored
    run_line("busy_start", 10'd100, 20, cyc);
    check("busy_start_cycles", cyc, 114);
    check("busy_start_hits", hit_count, 3);
    check("busy_start_writes", wa.size(), 48);
    check("busy_start_final_58", last_write(10'd58), 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
